sound_out_buffer: RTL and testbench

- Upstream feeder for the I2S sender.
- Accepts 32-bit sound-out words from the NeXT-side bus, buffers them in a small FIFO, and issues refill requests back to the NeXT side.
- Hands the I2S sender exactly one stereo sample per sample request.
- Expands packed 16-bit mono words into duplicated stereo samples.

---
 rtl/sound_out_buffer.sv | 208 ++++++++++++++++++++
 tb/tb_sound_out_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sound_out_buffer.sv
// rtl/sound_out_buffer.sv - NeXT sound-out word FIFO feeding the I2S sender; optional SOUND_OUT_UNDERRUN_CNT_EN adds underrun_cnt
module sound_out_buffer #(
    parameter int DEPTH = 8,
    parameter int BURST = 4
) (
    input  logic                   in_clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   mono,
    input  logic [31:0]            word_in,
    input  logic                   word_valid,
    output logic                   refill_req,
    input  logic                   sample_req,
    output logic [31:0]            out_data,
    output logic                   out_valid,
    output logic                   underrun,
`ifdef SOUND_OUT_UNDERRUN_CNT_EN
    output logic [15:0]            underrun_cnt,
`endif
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW:0]   REFILL_LIMIT = (LW + 1)'(DEPTH - BURST);
    localparam logic [LW-1:0] BURST_W      = LW'(BURST);
    localparam logic [LW-1:0] DEPTH_W      = LW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT} state_t;

    state_t        state;
    state_t        state_next;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] outstanding;
    logic          half_sel;
    logic          req_d;

    logic          req_evt;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          rd_en;
    logic          refill_fire;
    logic          pop;
    logic          half_next;
    logic          underrun_evt;
    logic [31:0]   sample_next;
    logic [31:0]   head;

    assign req_evt = sample_req & ~req_d;
    assign full    = (level == DEPTH_W);
    assign empty   = (level == '0);
    assign head    = mem[rd_ptr];
    // Words are only accepted while streaming; stop flushes, so it also blocks the write.
    assign wr_en   = word_valid && (state != S_IDLE) && !full && !stop;
    assign rd_en   = pop && !stop;

    // State register
    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and refill decision; stop overrides everything, including start
    always_comb begin
        state_next  = state;
        refill_fire = 1'b0;
        if (stop) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_next = S_RUN;
                    end
                end
                S_RUN: begin
                    if (({1'b0, level} + {1'b0, outstanding}) <= REFILL_LIMIT) begin
                        refill_fire = 1'b1;
                        state_next  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (word_valid && (outstanding == LW'(1))) begin
                        state_next = S_RUN;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Sample selection for a request event; mono is only re-sampled between words
    always_comb begin
        sample_next  = 32'd0;
        pop          = 1'b0;
        half_next    = half_sel;
        underrun_evt = 1'b0;
        if (req_evt && (state != S_IDLE)) begin
            if (empty) begin
                underrun_evt = 1'b1;
            end else if (!(mono || half_sel)) begin
                sample_next = head;
                pop         = 1'b1;
            end else if (!half_sel) begin
                sample_next = {head[31:16], head[31:16]};
                half_next   = 1'b1;
            end else begin
                sample_next = {head[15:0], head[15:0]};
                pop         = 1'b1;
                half_next   = 1'b0;
            end
        end
    end

    // FIFO storage; contents need no reset because level gates every read
    always_ff @(posedge in_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= word_in;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (stop) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Outstanding refill words; dropped words still count so a full FIFO cannot stall WAIT
    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else if (stop) begin
            outstanding <= '0;
        end else if (refill_fire) begin
            outstanding <= BURST_W;
        end else if ((state == S_WAIT) && word_valid && (outstanding != '0)) begin
            outstanding <= outstanding - LW'(1);
        end
    end

    // Registered outputs, request edge history, half-select and sticky underrun
    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            req_d      <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 32'd0;
            refill_req <= 1'b0;
            half_sel   <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            req_d      <= sample_req;
            out_valid  <= req_evt;
            refill_req <= refill_fire;
            if (req_evt) begin
                out_data <= sample_next;
            end
            half_sel <= stop ? 1'b0 : half_next;
            if (underrun_evt) begin
                underrun <= 1'b1;
            end else if (start) begin
                underrun <= 1'b0;
            end
        end
    end

`ifdef SOUND_OUT_UNDERRUN_CNT_EN
    // Saturating count of underrun events
    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            underrun_cnt <= 16'd0;
        end else if (underrun_evt) begin
            if (underrun_cnt != 16'hFFFF) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end else if (start) begin
            underrun_cnt <= 16'd0;
        end
    end
`endif

endmodule

// File: tb/tb_sound_out_buffer.sv
// tb/tb_sound_out_buffer.sv - directed self-checking bench for sound_out_buffer
module tb_sound_out_buffer;

    localparam int DEPTH = 8;
    localparam int BURST = 4;
    localparam int LW    = 4;

    logic          in_clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          mono = 1'b0;
    logic [31:0]   word_in = 32'd0;
    logic          word_valid = 1'b0;
    logic          sample_req = 1'b0;
    logic          refill_req;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          underrun;
    logic [LW-1:0] level;
`ifdef SOUND_OUT_UNDERRUN_CNT_EN
    logic [15:0]   underrun_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int refill_cnt = 0;
    int valid_cnt = 0;

    typedef struct {
        logic          mono;
        logic [31:0]   exp_data;
        logic [LW-1:0] exp_level;
        logic          exp_underrun;
    } rd_vec_t;

    rd_vec_t     rd_tab [6];
    logic [31:0] wr_tab [4];

    sound_out_buffer #(.DEPTH(DEPTH), .BURST(BURST)) dut (
        .in_clk      (in_clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .mono        (mono),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .refill_req  (refill_req),
        .sample_req  (sample_req),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .underrun    (underrun),
`ifdef SOUND_OUT_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt),
`endif
        .level       (level)
    );

    always #5 in_clk = ~in_clk;

    always @(negedge in_clk) begin
        if (refill_req === 1'b1) refill_cnt++;
        if (out_valid === 1'b1) valid_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        word_valid = 1'b1;
        word_in    = w;
        tick();
        word_valid = 1'b0;
    endtask

    initial begin
        int r0;
        int v0;

        rd_tab[0] = '{1'b0, 32'h11112222, 4'd3, 1'b0};
        rd_tab[1] = '{1'b0, 32'h33334444, 4'd2, 1'b0};
        rd_tab[2] = '{1'b1, 32'hAAAAAAAA, 4'd2, 1'b0};
        rd_tab[3] = '{1'b1, 32'h55555555, 4'd1, 1'b0};
        rd_tab[4] = '{1'b0, 32'h0BADF00D, 4'd0, 1'b0};
        rd_tab[5] = '{1'b0, 32'h00000000, 4'd0, 1'b1};
        wr_tab[0] = 32'h11112222;
        wr_tab[1] = 32'h33334444;
        wr_tab[2] = 32'hAAAA5555;
        wr_tab[3] = 32'h0BADF00D;

        repeat (2) @(posedge in_clk);
        #1 rst = 1'b0;
        chk("reset_refill_req", 32'(refill_req), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", out_data, 32'd0);
        chk("reset_underrun", 32'(underrun), 32'd0);
        chk("reset_level", 32'(level), 32'd0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("no_refill_on_start_edge", 32'(refill_req), 32'd0);
        r0 = refill_cnt;
        repeat (2) tick();
        chk("refill_within_2", 32'(refill_cnt - r0), 32'd1);
        r0 = refill_cnt;
        repeat (5) tick();
        chk("no_refill_while_wait", 32'(refill_cnt - r0), 32'd0);
        r0 = refill_cnt;
        for (int i = 0; i < 4; i++) send(wr_tab[i]);
        chk("no_refill_during_burst", 32'(refill_cnt - r0), 32'd0);
        chk("level_after_burst", 32'(level), 32'd4);
        tick();
        chk("refill_after_burst", 32'(refill_req), 32'd1);

        for (int i = 0; i < 6; i++) begin
            mono       = rd_tab[i].mono;
            sample_req = 1'b1;
            tick();
            chk($sformatf("rd%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("rd%0d_data", i), out_data, rd_tab[i].exp_data);
            chk($sformatf("rd%0d_level", i), 32'(level), 32'(rd_tab[i].exp_level));
            chk($sformatf("rd%0d_underrun", i), 32'(underrun), 32'(rd_tab[i].exp_underrun));
            sample_req = 1'b0;
            tick();
            chk($sformatf("rd%0d_valid_one_cycle", i), 32'(out_valid), 32'd0);
        end
        mono = 1'b0;
`ifdef SOUND_OUT_UNDERRUN_CNT_EN
        chk("underrun_cnt_one", 32'(underrun_cnt), 32'd1);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("underrun_cleared_by_start", 32'(underrun), 32'd0);
`ifdef SOUND_OUT_UNDERRUN_CNT_EN
        chk("underrun_cnt_cleared", 32'(underrun_cnt), 32'd0);
`endif

        r0 = refill_cnt;
        for (int i = 0; i < 8; i++) send(32'hC0DE0000 + 32'(i));
        chk("level_full", 32'(level), 32'd8);
        send(32'hFFFF0000);
        chk("level_full_after_drop", 32'(level), 32'd8);
        repeat (3) tick();
        chk("refills_during_fill", 32'(refill_cnt - r0), 32'd1);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        chk("full_fifo_head", out_data, 32'hC0DE0000);
        chk("level_after_pop", 32'(level), 32'd7);
        tick();

        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("level_after_stop", 32'(level), 32'd0);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
        chk("idle_valid", 32'(out_valid), 32'd1);
        chk("idle_data_zero", out_data, 32'd0);
        chk("idle_no_underrun", 32'(underrun), 32'd0);
        send(32'h12345678);
        chk("idle_word_dropped", 32'(level), 32'd0);

        v0 = valid_cnt;
        sample_req = 1'b1;
        repeat (10) tick();
        sample_req = 1'b0;
        repeat (2) tick();
        chk("held_req_one_sample", 32'(valid_cnt - v0), 32'd1);

        start = 1'b1;
        tick();
        start = 1'b0;
        send(32'h5A5A5A5A);
        chk("pre_reset_refill", 32'(refill_req), 32'd1);
        chk("pre_reset_level", 32'(level), 32'd1);
        rst = 1'b1;
        #2;
        chk("async_reset_refill", 32'(refill_req), 32'd0);
        chk("async_reset_level", 32'(level), 32'd0);
        @(posedge in_clk);
        #1 rst = 1'b0;
        tick();
        chk("post_reset_no_refill", 32'(refill_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
